// File: rtl/regfile_pkg.sv
// Shared constants, widened word/byte-enable types and the byte-merge helper
// used by both the storage update and the write-through bypass.
package regfile_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / BYTE_W;

    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_BE_W-1:0]   be_t;

    // Callers zero-extend into word_t/be_t and keep the low DATA_W bits of the result.
    function automatic word_t byte_merge(word_t old_word, word_t new_word, be_t be);
        word_t merged;
        for (int k = 0; k < int'(MAX_BE_W); k++) begin
            merged[k*BYTE_W +: BYTE_W] = be[k] ? new_word[k*BYTE_W +: BYTE_W]
                                               : old_word[k*BYTE_W +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Write/read bus of the register file: one byte-masked write port, two read ports
// and the current PC for the alias entry.
interface regfile_param_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned BE_W   = DATA_W / BYTE_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BE_W-1:0]   wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr0;
    logic [DATA_W-1:0] rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] pc_in;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_addr0, rd_addr1, pc_in,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_addr0, rd_addr1, pc_in,
        output rd_data0, rd_data1
    );

endinterface

// File: rtl/reg_be_en.sv
// One register-file entry: a D flop per bit with a hold mux, written byte-wise
// when en is high and the matching byte enable is set.
module reg_be_en
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [DATA_W-1:0]        d,
    output logic [DATA_W-1:0]        q
);

    word_t merged;

    assign merged = byte_merge(word_t'(q), word_t'(d), be_t'(be));

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= merged[DATA_W-1:0];
        end
    end

    if (DATA_W < MAX_DATA_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^merged[MAX_DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: byte-masked synchronous write, two combinational
// read ports with write-through bypass, optional PC-alias top entry.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned PC_ALIAS  = 1,
    parameter int unsigned PC_OFFSET = 8
) (
    input logic            clk,
    input logic            reset,
    regfile_param_if.slave bus
);

    localparam int unsigned       ADDR_W    = $clog2(NUM_REGS);
    localparam int unsigned       NUM_STORE = NUM_REGS - PC_ALIAS;
    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] PC_OFF    = DATA_W'(PC_OFFSET);

    if (DATA_W == 0 || DATA_W % BYTE_W != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("regfile_param: DATA_W must be a nonzero multiple of 8, at most %0d",
               MAX_DATA_W);
    end
    if (NUM_REGS < 2) begin : g_bad_depth
        $error("regfile_param: NUM_REGS must be at least 2");
    end
    if (PC_ALIAS > 1) begin : g_bad_alias
        $error("regfile_param: PC_ALIAS must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [NUM_STORE];
    logic              wr_ok;
    logic [DATA_W-1:0] wr_old;
    word_t             byp_wide;
    logic [DATA_W-1:0] byp_word;
    logic [DATA_W-1:0] pc_read;

    // The alias slot has no storage, so writes to it fall out of the range test.
    assign wr_ok = bus.wr_en && !reset && (32'(bus.wr_addr) < NUM_STORE);

    for (genvar i = 0; i < int'(NUM_STORE); i++) begin : g_entry
        reg_be_en #(
            .DATA_W (DATA_W)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .en    (wr_ok && (bus.wr_addr == ADDR_W'(i))),
            .be    (bus.wr_be),
            .d     (bus.wr_data),
            .q     (mem[i])
        );
    end

    // Bypass word equals what the addressed entry will hold after this edge.
    assign wr_old   = wr_ok ? mem[bus.wr_addr] : '0;
    assign byp_wide = byte_merge(word_t'(wr_old), word_t'(bus.wr_data), be_t'(bus.wr_be));
    assign byp_word = byp_wide[DATA_W-1:0];
    assign pc_read  = bus.pc_in + PC_OFF;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = (p == 0) ? bus.rd_addr0 : bus.rd_addr1;

        always_comb begin
            if (PC_ALIAS != 0 && addr == PC_ADDR) begin
                data = pc_read;
            end else if (32'(addr) >= NUM_REGS) begin
                data = '0;
            end else if (wr_ok && addr == bus.wr_addr) begin
                data = byp_word;
            end else begin
                data = mem[addr];
            end
        end
    end

    assign bus.rd_data0 = g_rd[0].data;
    assign bus.rd_data1 = g_rd[1].data;

    if (DATA_W < MAX_DATA_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^byp_wide[MAX_DATA_W-1:DATA_W];
    end
    if (PC_ALIAS == 0) begin : g_unused_pc
        logic unused_pc;
        assign unused_pc = ^pc_read;
    end

    assert property (@(posedge clk)
        bus.wr_en |-> !$isunknown({bus.wr_addr, bus.wr_be, bus.wr_data}));
    assert property (@(posedge clk) !$isunknown({bus.rd_addr0, bus.rd_addr1}));

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: directed scenarios then random traffic on a 16-entry PC-alias
// file and a 12-entry plain file, both checked against an array model.
module tb_regfile_param;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [12];

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .NUM_REGS(16)) bus_a ();
    regfile_param_if #(.DATA_W(32), .NUM_REGS(12)) bus_b ();

    regfile_param #(
        .DATA_W    (32),
        .NUM_REGS  (16),
        .PC_ALIAS  (1),
        .PC_OFFSET (8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_param #(
        .DATA_W    (32),
        .NUM_REGS  (12),
        .PC_ALIAS  (0),
        .PC_OFFSET (8)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w,
                                          logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mask = mask | (32'hFF << (8 * k));
        end
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    function automatic logic [31:0] exp_a(logic [3:0] a);
        if (a == 4'd15) return bus_a.pc_in + 32'd8;
        if (!reset && bus_a.wr_en && bus_a.wr_addr == a)
            return merge(mem_a[a], bus_a.wr_data, bus_a.wr_be);
        return mem_a[a];
    endfunction

    function automatic logic [31:0] exp_b(logic [3:0] a);
        if (a >= 4'd12) return 32'h0;
        if (!reset && bus_b.wr_en && bus_b.wr_addr == a)
            return merge(mem_b[a], bus_b.wr_data, bus_b.wr_be);
        return mem_b[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic we, input logic [3:0] wa, input logic [3:0] be,
                           input logic [31:0] wd, input logic [3:0] r0, input logic [3:0] r1,
                           input logic [31:0] pc);
        bus_a.wr_en    = we;
        bus_a.wr_addr  = wa;
        bus_a.wr_be    = be;
        bus_a.wr_data  = wd;
        bus_a.rd_addr0 = r0;
        bus_a.rd_addr1 = r1;
        bus_a.pc_in    = pc;
    endtask

    task automatic drive_b(input logic we, input logic [3:0] wa, input logic [3:0] be,
                           input logic [31:0] wd, input logic [3:0] r0, input logic [3:0] r1);
        bus_b.wr_en    = we;
        bus_b.wr_addr  = wa;
        bus_b.wr_be    = be;
        bus_b.wr_data  = wd;
        bus_b.rd_addr0 = r0;
        bus_b.rd_addr1 = r1;
        bus_b.pc_in    = 32'h0;
    endtask

    task automatic update_model();
        if (reset) begin
            foreach (mem_a[i]) mem_a[i] = 32'h0;
            foreach (mem_b[i]) mem_b[i] = 32'h0;
        end else begin
            if (bus_a.wr_en && bus_a.wr_addr != 4'd15)
                mem_a[bus_a.wr_addr] = merge(mem_a[bus_a.wr_addr], bus_a.wr_data, bus_a.wr_be);
            if (bus_b.wr_en && bus_b.wr_addr < 4'd12)
                mem_b[bus_b.wr_addr] = merge(mem_b[bus_b.wr_addr], bus_b.wr_data, bus_b.wr_be);
        end
    endtask

    // Check all four read ports against the model, then advance one clock.
    task automatic step(input string tag);
        #1;
        chk({tag, "_a0"}, bus_a.rd_data0, exp_a(bus_a.rd_addr0));
        chk({tag, "_a1"}, bus_a.rd_data1, exp_a(bus_a.rd_addr1));
        chk({tag, "_b0"}, bus_b.rd_data0, exp_b(bus_b.rd_addr0));
        chk({tag, "_b1"}, bus_b.rd_data1, exp_b(bus_b.rd_addr1));
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] wa;
        logic [3:0] r0;
        logic [3:0] r1;

        reset = 1'b1;
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0, 32'h0);
        drive_b(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        foreach (mem_a[i]) mem_a[i] = 32'h0;
        foreach (mem_b[i]) mem_b[i] = 32'h0;
        reset = 1'b0;

        // Reset contents and PC alias
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd15, 32'h100);
        #1;
        chk("t1_zero", bus_a.rd_data0, 32'h0);
        chk("t1_pc", bus_a.rd_data1, 32'h108);
        for (int i = 0; i < 16; i += 2) begin
            drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'(i), 4'(i + 1), 32'h100);
            step("t1_all");
        end

        // Full-word write
        drive_a(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 4'd0, 4'd1, 32'h0);
        step("t2_wr");
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd3, 4'd4, 32'h0);
        #1;
        chk("t2_rd", bus_a.rd_data0, 32'hDEADBEEF);
        chk("t2_other", bus_a.rd_data1, 32'h0);
        step("t2_rd");

        // Partial-byte write with same-cycle bypass
        drive_a(1'b1, 4'd5, 4'hF, 32'h11223344, 4'd0, 4'd0, 32'h0);
        step("t3_init");
        drive_a(1'b1, 4'd5, 4'b0101, 32'hAABBCCDD, 4'd5, 4'd3, 32'h0);
        #1;
        chk("t3_byp", bus_a.rd_data0, 32'h11BB33DD);
        step("t3_byp");
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd5, 32'h0);
        #1;
        chk("t3_rd", bus_a.rd_data1, 32'h11BB33DD);
        step("t3_rd");

        // Write to the PC alias is dropped
        drive_a(1'b1, 4'd15, 4'hF, 32'h12345678, 4'd15, 4'd3, 32'h200);
        #1;
        chk("t4_pc_byp", bus_a.rd_data0, 32'h208);
        step("t4_wr");
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd15, 4'd3, 32'h200);
        #1;
        chk("t4_pc", bus_a.rd_data0, 32'h208);
        chk("t4_keep", bus_a.rd_data1, 32'hDEADBEEF);
        for (int i = 0; i < 16; i += 2) begin
            drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'(i), 4'(i + 1), 32'h200);
            step("t4_all");
        end

        // Reset beats a same-cycle write, and no bypass during reset
        drive_a(1'b1, 4'd7, 4'hF, 32'hFFFFFFFF, 4'd0, 4'd0, 32'h0);
        step("t5_init");
        reset = 1'b1;
        drive_a(1'b1, 4'd7, 4'hF, 32'hCAFEF00D, 4'd7, 4'd7, 32'h0);
        #1;
        chk("t5_nobyp", bus_a.rd_data0, 32'hFFFFFFFF);
        step("t5_rst");
        reset = 1'b0;
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd7, 4'd3, 32'h0);
        #1;
        chk("t5_clr7", bus_a.rd_data0, 32'h0);
        chk("t5_clr3", bus_a.rd_data1, 32'h0);
        step("t5_rd");

        // 12-entry plain file: out-of-range write/read, dual bypass, empty byte mask
        drive_a(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0, 32'h0);
        drive_b(1'b1, 4'd13, 4'hF, 32'h12345678, 4'd13, 4'd11);
        #1;
        chk("t6_rd13", bus_b.rd_data0, 32'h0);
        step("t6_oob");
        drive_b(1'b1, 4'd2, 4'hF, 32'h55AA55AA, 4'd2, 4'd2);
        #1;
        chk("t6_byp0", bus_b.rd_data0, 32'h55AA55AA);
        chk("t6_byp1", bus_b.rd_data1, 32'h55AA55AA);
        step("t6_byp");
        drive_b(1'b1, 4'd2, 4'h0, 32'hFFFFFFFF, 4'd2, 4'd13);
        #1;
        chk("t6_be0", bus_b.rd_data0, 32'h55AA55AA);
        chk("t6_rd13b", bus_b.rd_data1, 32'h0);
        step("t6_be0");
        for (int i = 0; i < 16; i += 2) begin
            drive_b(1'b0, 4'd0, 4'h0, 32'h0, 4'(i), 4'(i + 1));
            step("t6_all");
        end

        // Random traffic, reads biased towards the write address
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            wa = 4'($urandom_range(0, 15));
            r0 = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
            r1 = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
            drive_a(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
                    r0, r1, $urandom);
            wa = 4'($urandom_range(0, 15));
            r0 = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
            r1 = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
            drive_b(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
                    r0, r1);
            step("rnd");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
